backprop_pipe_reg: RTL and testbench

- Elastic, parametrised pipeline register for the backprop datapath.
- Carries NUM_BUSES packed vector buses plus one control word through DEPTH register stages under a valid/ready handshake.
- Holes in the pipeline collapse, and a synchronous flush is provided.
- Sits between backprop compute stages and replaces fixed single-cycle bus delays wherever downstream can stall.

---
 rtl/backprop_pipe_pkg.sv | 23 ++
 rtl/backprop_pipe_stage.sv | 49 ++++
 rtl/backprop_pipe_reg.sv | 117 +++++++++++
 tb/tb_backprop_pipe_reg.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/backprop_pipe_pkg.sv
// Shared constants for the backprop elastic pipeline register: default widths,
// bus ordering inside the packed vector bundle, and the bus width helper.
package backprop_pipe_pkg;

   localparam int DEF_SIZE      = 3;
   localparam int DEF_DATA_SIZE = 16;
   localparam int DEF_NUM_BUSES = 6;
   localparam int DEF_CTRL_SIZE = 100;
   localparam int DEF_DEPTH     = 1;

   // Bus slot k occupies bits [(k+1)*bus_width-1 : k*bus_width] of the bundle.
   localparam int BUS_DIFF_TO_ALL   = 0;
   localparam int BUS_DIFF_START    = 1;
   localparam int BUS_DIFF_DENSE    = 2;
   localparam int BUS_DIFF_COST     = 3;
   localparam int BUS_Z             = 4;
   localparam int BUS_PREDICT_VALUE = 5;

   function automatic int bus_width(input int size, input int data_size);
      return size * data_size;
   endfunction

endpackage

// File: rtl/backprop_pipe_stage.sv
// One elastic pipeline stage: valid bit plus payload register. The payload only
// loads when a valid word arrives, so bubbles do not toggle the wide data flops.
module backprop_pipe_stage
   import backprop_pipe_pkg::*;
#(
   parameter int W = DEF_CTRL_SIZE
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         adv,
   input  logic         src_valid,
   input  logic [W-1:0] src_data,
   output logic         valid,
   output logic [W-1:0] data
);

   logic         valid_q;
   logic         valid_d;
   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (adv) begin
         valid_d = src_valid;
         if (src_valid) begin
            data_d = src_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/backprop_pipe_reg.sv
// Elastic DEPTH-stage pipeline register for the backprop bus bundle + control word.
// Optional registered occupancy output enabled by BACKPROP_PIPE_REG_OCC_EN.
module backprop_pipe_reg
   import backprop_pipe_pkg::*;
#(
   parameter int SIZE      = DEF_SIZE,
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int NUM_BUSES = DEF_NUM_BUSES,
   parameter int CTRL_SIZE = DEF_CTRL_SIZE,
   parameter int DEPTH     = DEF_DEPTH
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [NUM_BUSES*SIZE*DATA_SIZE-1:0] in_bus,
   input  logic [CTRL_SIZE-1:0]                in_ctrl,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [NUM_BUSES*SIZE*DATA_SIZE-1:0] out_bus,
   output logic [CTRL_SIZE-1:0]                out_ctrl
`ifdef BACKPROP_PIPE_REG_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0]          occupancy
`endif
);

   localparam int BUS_W   = NUM_BUSES * bus_width(SIZE, DATA_SIZE);
   localparam int STAGE_W = BUS_W + CTRL_SIZE;

   if (DEPTH < 1) begin : g_bad_depth
      $error("backprop_pipe_reg: DEPTH must be at least 1");
   end

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] src_valid;
   logic [STAGE_W-1:0] d        [DEPTH];
   logic [STAGE_W-1:0] src_data [DEPTH];

   // adv[i] = !v[i] | adv[i+1] unrolled: a stage moves if any stage at or
   // after it is empty, or the sink takes the head word.
   always_comb begin
      adv = '0;
      for (int i = 0; i < DEPTH; i++) begin
         adv[i] = out_ready;
         for (int j = i; j < DEPTH; j++) begin
            if (!v[j]) begin
               adv[i] = 1'b1;
            end
         end
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign src_valid[i] = in_valid;
         assign src_data[i]  = {in_ctrl, in_bus};
      end else begin : g_body
         assign src_valid[i] = v[i-1];
         assign src_data[i]  = d[i-1];
      end

      backprop_pipe_stage #(
         .W (STAGE_W)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .adv       (adv[i]),
         .src_valid (src_valid[i]),
         .src_data  (src_data[i]),
         .valid     (v[i]),
         .data      (d[i])
      );
   end

   assign in_ready  = adv[0] & ~flush;
   assign out_valid = v[DEPTH-1] & ~flush;
   assign out_bus   = d[DEPTH-1][BUS_W-1:0];
   assign out_ctrl  = d[DEPTH-1][STAGE_W-1:BUS_W];

`ifdef BACKPROP_PIPE_REG_OCC_EN
   localparam int OCC_W = $clog2(DEPTH+1);

   logic             in_xfer;
   logic             out_xfer;
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (in_xfer && !out_xfer) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (out_xfer && !in_xfer) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_backprop_pipe_reg.sv
// Directed bench for backprop_pipe_reg at DEPTH=3; occupancy checks are active
// only when BACKPROP_PIPE_REG_OCC_EN is defined.
module tb_backprop_pipe_reg;

   localparam int DEPTH  = 3;
   localparam int BUS_W  = 6 * 3 * 16;
   localparam int CTRL_W = 100;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [BUS_W-1:0]  in_bus = '0;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [BUS_W-1:0]  out_bus;
   logic [CTRL_W-1:0] out_ctrl;
`ifdef BACKPROP_PIPE_REG_OCC_EN
   logic [1:0]        occupancy;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   backprop_pipe_reg #(
      .SIZE      (3),
      .DATA_SIZE (16),
      .NUM_BUSES (6),
      .CTRL_SIZE (CTRL_W),
      .DEPTH     (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bus    (in_bus),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bus   (out_bus),
      .out_ctrl  (out_ctrl)
`ifdef BACKPROP_PIPE_REG_OCC_EN
      ,
      .occupancy (occupancy)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic check_occ(input string tag, input int exp);
`ifdef BACKPROP_PIPE_REG_OCC_EN
      check(tag, 512'(occupancy), 512'(exp));
`endif
   endtask

   // Word n: every element of bus k equals n + k*0x100.
   function automatic logic [BUS_W-1:0] mk_bus(input int n);
      logic [BUS_W-1:0] b;
      b = '0;
      for (int k = 0; k < 6; k++)
         for (int e = 0; e < 3; e++)
            b[(k*3+e)*16 +: 16] = 16'(n + k*256);
      return b;
   endfunction

   function automatic logic [CTRL_W-1:0] mk_ctrl(input int n);
      return CTRL_W'(n + 1000);
   endfunction

   task automatic drive(input int n, input logic [CTRL_W-1:0] c);
      in_valid = 1'b1;
      in_bus   = mk_bus(n);
      in_ctrl  = c;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int acc;
      int got;
      logic in_x;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 512'(out_valid), 512'(0));
      check("rst_out_bus",   512'(out_bus),   512'(0));
      check("rst_out_ctrl",  512'(out_ctrl),  512'(0));
      check("rst_in_ready",  512'(in_ready),  512'(1));
      check_occ("rst_occ", 0);
      cycle();
      rst = 1'b0;

      // 1: A,B,C back-to-back, out_ready high, latency 3
      out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c < 3) drive(c + 1, CTRL_W'(5));
         else idle();
         @(negedge clk);
         check("t1_in_ready", 512'(in_ready), 512'(1));
         check("t1_out_valid", 512'(out_valid), 512'((c >= 3 && c <= 5) ? 1 : 0));
         if (c >= 3 && c <= 5) begin
            check("t1_out_bus", 512'(out_bus), 512'(mk_bus(c - 2)));
            check("t1_out_ctrl", 512'(out_ctrl), 512'(5));
         end
         cycle();
      end

      // 2: stall with 5 words, then drain in order
      out_ready = 1'b0;
      idx = 1;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         drive(idx, mk_ctrl(idx));
         @(negedge clk);
         check("t2_in_ready_stall", 512'(in_ready), 512'((c < 3) ? 1 : 0));
         in_x = in_valid & in_ready;
         if (c >= 3) begin
            check("t2_hold_valid", 512'(out_valid), 512'(1));
            check("t2_hold_bus", 512'(out_bus), 512'(mk_bus(1)));
            check("t2_hold_ctrl", 512'(out_ctrl), 512'(mk_ctrl(1)));
         end
         cycle();
         if (in_x) begin
            acc++;
            idx++;
         end
      end
      check("t2_accepted", 512'(acc), 512'(3));
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && got < 5; c++) begin
         if (idx <= 5) drive(idx, mk_ctrl(idx));
         else idle();
         @(negedge clk);
         in_x = in_valid & in_ready;
         if (out_valid) begin
            check("t2_drain_bus", 512'(out_bus), 512'(mk_bus(got + 1)));
            check("t2_drain_ctrl", 512'(out_ctrl), 512'(mk_ctrl(got + 1)));
            got++;
         end
         cycle();
         if (in_x) idx++;
      end
      idle();
      check("t2_drain_count", 512'(got), 512'(5));
      @(negedge clk);
      check("t2_empty", 512'(out_valid), 512'(0));
      cycle();

      // 3: bubble collapses under stall
      out_ready = 1'b0;
      drive(11, mk_ctrl(11)); cycle();
      idle();                 cycle();
      drive(12, mk_ctrl(12)); cycle();
      idle();                 cycle();
      cycle();
      @(negedge clk);
      check("t3_out_valid", 512'(out_valid), 512'(1));
      check("t3_out_bus", 512'(out_bus), 512'(mk_bus(11)));
      check("t3_in_ready", 512'(in_ready), 512'(1));
      check_occ("t3_occ", 2);
      out_ready = 1'b1;
      cycle();
      @(negedge clk);
      check("t3_second_valid", 512'(out_valid), 512'(1));
      check("t3_second_bus", 512'(out_bus), 512'(mk_bus(12)));
      cycle();
      @(negedge clk);
      check("t3_empty", 512'(out_valid), 512'(0));

      // 4: flush with two words held and an input word offered
      out_ready = 1'b0;
      cycle();
      drive(21, mk_ctrl(21)); cycle();
      drive(22, mk_ctrl(22)); cycle();
      idle();                 cycle();
      @(negedge clk);
      check("t4_pre_valid", 512'(out_valid), 512'(1));
      check_occ("t4_pre_occ", 2);
      cycle();
      flush = 1'b1;
      drive(23, mk_ctrl(23));
      @(negedge clk);
      check("t4_flush_in_ready", 512'(in_ready), 512'(0));
      check("t4_flush_out_valid", 512'(out_valid), 512'(0));
      cycle();
      flush = 1'b0;
      idle();
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_post_valid", 512'(out_valid), 512'(0));
      check("t4_post_in_ready", 512'(in_ready), 512'(1));
      check_occ("t4_post_occ", 0);
      for (int c = 0; c < 4; c++) begin
         cycle();
         @(negedge clk);
         check("t4_nothing_emerges", 512'(out_valid), 512'(0));
      end
      cycle();

      // 5: asynchronous reset with words in flight
      out_ready = 1'b0;
      drive(31, mk_ctrl(31)); cycle();
      drive(32, mk_ctrl(32)); cycle();
      idle();                 cycle();
      @(negedge clk);
      check("t5_pre_valid", 512'(out_valid), 512'(1));
      #2 rst = 1'b1;
      #1;
      check("t5_rst_valid", 512'(out_valid), 512'(0));
      check("t5_rst_bus", 512'(out_bus), 512'(0));
      check("t5_rst_ctrl", 512'(out_ctrl), 512'(0));
      cycle();
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("t5_in_ready", 512'(in_ready), 512'(1));
      check_occ("t5_occ", 0);
      cycle();
      @(negedge clk);
      check("t5_lost", 512'(out_valid), 512'(0));
      cycle();

      // 6: full pipe streaming at one word per cycle
      out_ready = 1'b0;
      drive(101, mk_ctrl(101)); cycle();
      drive(102, mk_ctrl(102)); cycle();
      drive(103, mk_ctrl(103)); cycle();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(104 + i, mk_ctrl(104 + i));
         @(negedge clk);
         check("t6_in_ready", 512'(in_ready), 512'(1));
         check("t6_out_valid", 512'(out_valid), 512'(1));
         check("t6_out_bus", 512'(out_bus), 512'(mk_bus(101 + i)));
         check_occ("t6_occ", 3);
         cycle();
      end
      idle();
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("t6_tail_valid", 512'(out_valid), 512'(1));
         check("t6_tail_bus", 512'(out_bus), 512'(mk_bus(111 + j)));
         cycle();
      end
      @(negedge clk);
      check("t6_final_empty", 512'(out_valid), 512'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
